blit_command_encoder: RTL and testbench
=======================================

BLIT_COMMAND_ENCODER -- requirements
Module: blit_command_encoder

Interface
REQ-001 clock  input  1  system clock; all state on rising edge.
REQ-002 reset  input  1  synchronous, active-high.
REQ-003 req_valid  input  1  high = request presented.
REQ-004 req_ready  output  1  high = encoder idle, accepts request this cycle.
REQ-005 req_op  input  2  0=NOP, 1=DRAW_RECT, 2=COPY_RECT, 3=SETUP.
REQ-006 req_priv  input  1  privilege bit, carried on every emitted word of the request.
REQ-007 req_color  input  8  draw colour.
REQ-008 req_x1, req_y1, req_x2, req_y2, req_src_x, req_src_y  input  16 each  rectangle and copy-source coordinates.
REQ-009 req_dest_stride, req_src_stride  input  16 each; req_dest_addr, req_src_addr, req_font_addr  input  26 each  SETUP surface parameters.
REQ-010 req_clip_x1, req_clip_y1, req_clip_x2, req_clip_y2, req_offset_x, req_offset_y  input  16 each; req_font_w, req_font_h  input  8 each  SETUP parameters.
REQ-011 fifo_slots_free  input  10  free slots reported by the command parser (registered there, lags writes by up to 2 cycles).
REQ-012 blit_valid  output  1  one-cycle write strobe, one word per strobe.
REQ-013 blit_command  output  32  command word.
REQ-014 blit_privaledge  output  1  privilege bit accompanying blit_command.
REQ-015 busy  output  1  high whenever state != IDLE.
REQ-016 cmd_count  output  16  number of requests fully emitted, wraps 0xFFFF->0.

Function
REQ-017 All inputs req_* are captured into holding registers on the edge where req_valid && req_ready; later changes are ignored until the next acceptance.
REQ-018 Word sequences (word 0 first): NOP = {0x00000000} (1 word); DRAW_RECT = {0x01,16'h0,color}, {y1,x1}, {y2,x2} (3); COPY_RECT = {0x02,16'h0,color}, {y1,x1}, {y2,x2}, {src_y,src_x} (4); SETUP = {0xFF,8'h0,dest_stride}, {6'h0,dest_addr}, {clip_y1,clip_x1}, {clip_y2,clip_x2}, {offset_y,offset_x}, {6'h0,src_addr}, {16'h0,src_stride}, {6'h0,font_addr}, {16'h0,font_h,font_w} (9). Coordinates pass unmodified (no offset applied).
REQ-019 States: IDLE, WAIT_SPACE, EMIT, SETTLE.
REQ-020 IDLE: req_ready=1; on acceptance -> WAIT_SPACE, word count N latched per REQ-018.
REQ-021 WAIT_SPACE: when fifo_slots_free >= N+2 (11-bit unsigned compare) -> EMIT, word index = 0; else remain.
REQ-022 EMIT: blit_valid=1 for exactly N consecutive cycles, word index k presented in the k-th cycle; no gaps; after word N-1 -> SETTLE and cmd_count increments by 1.
REQ-023 SETTLE: lasts exactly 2 cycles (absorbs parser occupancy lag), then IDLE.
REQ-024 Outputs blit_valid, blit_command, blit_privaledge are registered; blit_command and blit_privaledge are 0 whenever blit_valid=0.
REQ-025 Latency: acceptance at edge E0; with space available, word 0 valid in cycle following edge E1 = E0+2; req_ready returns high N+2 cycles after word 0 first appears... (SETTLE exit).
REQ-026 SETUP with req_priv=0 is still emitted unchanged with blit_privaledge=0 (parser decides rejection).
REQ-027 fifo_slots_free changes during EMIT do not stall or abort emission.
REQ-028 req_valid while busy: not accepted, no side effects.

Reset
REQ-029 On reset: state=IDLE, req_ready=1, busy=0, blit_valid=0, blit_command=0, blit_privaledge=0, cmd_count=0, word index=0.
REQ-030 Reset mid-EMIT: blit_valid low from the next edge, remaining words discarded, cmd_count not incremented; parser shall be reset in the same cycle.

Verification
REQ-031 DRAW_RECT color=0x2A, (x1,y1)=(10,20), (x2,y2)=(50,60), slots=1023 -> words 0x0100002A, 0x0014000A, 0x003C0032 on 3 consecutive cycles, cmd_count=1.
REQ-032 SETUP priv=1, dest_stride=640, dest_addr=0x100000, font_w=8, font_h=12 -> 9 words, first 0xFF000280, second 0x00100000, last 0x00000C08, blit_privaledge=1 on all 9.
REQ-033 COPY_RECT with fifo_slots_free=5 -> encoder holds in WAIT_SPACE, no blit_valid; raise to 6 -> 4 words emitted back-to-back.
REQ-034 Back-to-back requests with req_valid held high -> second accepted only after 2-cycle SETTLE; exactly 2 idle-strobe cycles minimum between bursts.
REQ-035 Reset asserted on 5th SETUP word -> blit_valid=0 next cycle, cmd_count=0, req_ready=1; subsequent NOP emits 0x00000000 once.
REQ-036 Full loop with command parser model: 1000 random requests -> parser never reports FIFO overflow, decoded parameters match requests.

Source files
------------

// File: rtl/blit_command_encoder_if.sv
// Request, FIFO-space and command-word signals between a blit requester,
// the command encoder and the downstream command parser.
interface blit_command_encoder_if;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_op;
   logic        req_priv;
   logic [7:0]  req_color;
   logic [15:0] req_x1, req_y1, req_x2, req_y2, req_src_x, req_src_y;
   logic [15:0] req_dest_stride, req_src_stride;
   logic [25:0] req_dest_addr, req_src_addr, req_font_addr;
   logic [15:0] req_clip_x1, req_clip_y1, req_clip_x2, req_clip_y2;
   logic [15:0] req_offset_x, req_offset_y;
   logic [7:0]  req_font_w, req_font_h;
   logic [9:0]  fifo_slots_free;
   logic        blit_valid;
   logic [31:0] blit_command;
   logic        blit_privaledge;

   // requester/parser side
   modport master (
      output req_valid, req_op, req_priv, req_color,
             req_x1, req_y1, req_x2, req_y2, req_src_x, req_src_y,
             req_dest_stride, req_src_stride, req_dest_addr, req_src_addr, req_font_addr,
             req_clip_x1, req_clip_y1, req_clip_x2, req_clip_y2,
             req_offset_x, req_offset_y, req_font_w, req_font_h, fifo_slots_free,
      input  req_ready, blit_valid, blit_command, blit_privaledge
   );

   // encoder side
   modport slave (
      input  req_valid, req_op, req_priv, req_color,
             req_x1, req_y1, req_x2, req_y2, req_src_x, req_src_y,
             req_dest_stride, req_src_stride, req_dest_addr, req_src_addr, req_font_addr,
             req_clip_x1, req_clip_y1, req_clip_x2, req_clip_y2,
             req_offset_x, req_offset_y, req_font_w, req_font_h, fifo_slots_free,
      output req_ready, blit_valid, blit_command, blit_privaledge
   );
endinterface

// File: rtl/blit_command_encoder.sv
// Blit command encoder: latches one request, waits for parser FIFO space,
// then streams the request's command words one per cycle, and settles for
// two cycles so the parser's lagging slot count catches up.
module blit_command_encoder (
   input  logic                         clock,
   input  logic                         reset,
   blit_command_encoder_if.slave        bus,
   output logic                         busy,
   output logic [15:0]                  cmd_count
);
   localparam logic [1:0] OP_NOP = 2'd0, OP_DRAW = 2'd1, OP_COPY = 2'd2, OP_SETUP = 2'd3;

   typedef enum logic [1:0] {IDLE, WAIT_SPACE, EMIT, SETTLE} state_t;

   typedef struct packed {
      logic [1:0]  op;
      logic        priv;
      logic [7:0]  color;
      logic [15:0] x1, y1, x2, y2, src_x, src_y;
      logic [15:0] dest_stride, src_stride;
      logic [25:0] dest_addr, src_addr, font_addr;
      logic [15:0] clip_x1, clip_y1, clip_x2, clip_y2, offset_x, offset_y;
      logic [7:0]  font_w, font_h;
   } req_t;

   state_t      state;
   req_t        hold;
   req_t        req_in;
   logic [3:0]  n_words;
   logic [3:0]  word_idx;
   logic        settle_cnt;
   logic [31:0] word;
   logic        space_ok;

   assign req_in = '{op: bus.req_op, priv: bus.req_priv, color: bus.req_color,
                     x1: bus.req_x1, y1: bus.req_y1, x2: bus.req_x2, y2: bus.req_y2,
                     src_x: bus.req_src_x, src_y: bus.req_src_y,
                     dest_stride: bus.req_dest_stride, src_stride: bus.req_src_stride,
                     dest_addr: bus.req_dest_addr, src_addr: bus.req_src_addr,
                     font_addr: bus.req_font_addr,
                     clip_x1: bus.req_clip_x1, clip_y1: bus.req_clip_y1,
                     clip_x2: bus.req_clip_x2, clip_y2: bus.req_clip_y2,
                     offset_x: bus.req_offset_x, offset_y: bus.req_offset_y,
                     font_w: bus.req_font_w, font_h: bus.req_font_h};

   function automatic logic [3:0] words_for(input logic [1:0] op);
      case (op)
         OP_DRAW:  return 4'd3;
         OP_COPY:  return 4'd4;
         OP_SETUP: return 4'd9;
         default:  return 4'd1;
      endcase
   endfunction

   assign bus.req_ready = (state == IDLE);
   assign busy          = (state != IDLE);
   // two words of headroom cover the parser's registered slot count
   assign space_ok      = {1'b0, bus.fifo_slots_free} >= ({7'd0, n_words} + 11'd2);

   // select the command word for the current index of the held request
   always_comb begin
      word = 32'h0;
      case (hold.op)
         OP_DRAW, OP_COPY:
            case (word_idx)
               4'd0:    word = {6'h0, hold.op, 16'h0, hold.color};
               4'd1:    word = {hold.y1, hold.x1};
               4'd2:    word = {hold.y2, hold.x2};
               4'd3:    word = {hold.src_y, hold.src_x};
               default: word = 32'h0;
            endcase
         OP_SETUP:
            case (word_idx)
               4'd0:    word = {8'hFF, 8'h0, hold.dest_stride};
               4'd1:    word = {6'h0, hold.dest_addr};
               4'd2:    word = {hold.clip_y1, hold.clip_x1};
               4'd3:    word = {hold.clip_y2, hold.clip_x2};
               4'd4:    word = {hold.offset_y, hold.offset_x};
               4'd5:    word = {6'h0, hold.src_addr};
               4'd6:    word = {16'h0, hold.src_stride};
               4'd7:    word = {6'h0, hold.font_addr};
               4'd8:    word = {16'h0, hold.font_h, hold.font_w};
               default: word = 32'h0;
            endcase
         default: word = 32'h0;
      endcase
   end

   // control FSM with registered strobe/word outputs
   always_ff @(posedge clock) begin
      if (reset) begin
         state               <= IDLE;
         hold                <= '0;
         n_words             <= 4'd0;
         word_idx            <= 4'd0;
         settle_cnt          <= 1'b0;
         cmd_count           <= 16'd0;
         bus.blit_valid      <= 1'b0;
         bus.blit_command    <= 32'h0;
         bus.blit_privaledge <= 1'b0;
      end else begin
         bus.blit_valid      <= 1'b0;
         bus.blit_command    <= 32'h0;
         bus.blit_privaledge <= 1'b0;
         case (state)
            IDLE:
               if (bus.req_valid) begin
                  hold    <= req_in;
                  n_words <= words_for(bus.req_op);
                  state   <= WAIT_SPACE;
               end
            WAIT_SPACE:
               if (space_ok) begin
                  word_idx <= 4'd0;
                  state    <= EMIT;
               end
            EMIT:
               // slot count is deliberately ignored here: space was reserved up front
               if (word_idx == n_words) begin
                  settle_cnt <= 1'b0;
                  cmd_count  <= cmd_count + 16'd1;
                  state      <= SETTLE;
               end else begin
                  bus.blit_valid      <= 1'b1;
                  bus.blit_command    <= word;
                  bus.blit_privaledge <= hold.priv;
                  word_idx            <= word_idx + 4'd1;
               end
            SETTLE:
               if (settle_cnt) begin
                  word_idx <= 4'd0;
                  state    <= IDLE;
               end else begin
                  settle_cnt <= 1'b1;
               end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_blit_command_encoder.sv
// Directed and randomized bench for blit_command_encoder with a command
// parser FIFO model that reports free slots two cycles late.
module tb_blit_command_encoder;
   localparam int DEPTH = 12;

   typedef struct {
      bit [1:0]  op;
      bit        priv;
      bit [7:0]  color;
      bit [15:0] x1, y1, x2, y2, sx, sy, dst_stride, src_stride;
      bit [15:0] cx1, cy1, cx2, cy2, ox, oy;
      bit [25:0] dst_addr, src_addr, font_addr;
      bit [7:0]  fw, fh;
   } req_t;

   logic        clock;
   logic        reset;
   logic        busy;
   logic [15:0] cmd_count;

   blit_command_encoder_if bif ();

   blit_command_encoder dut (
      .clock     (clock),
      .reset     (reset),
      .bus       (bif.slave),
      .busy      (busy),
      .cmd_count (cmd_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int          cyc = 0;
   int          n_assert = 0;
   int          n_fail = 0;
   int          nz_err = 0;
   logic [32:0] mon_w[$];
   int          mon_c[$];
   logic [32:0] exp_q[$];
   logic [15:0] cnt_model = 16'd0;

   logic        par_mode = 1'b0;
   logic        par_ovf = 1'b0;
   int          occ = 0;
   logic [9:0]  free_d1 = 10'(DEPTH);
   logic [9:0]  free_d2 = 10'(DEPTH);
   logic [9:0]  slots_dir = 10'd1023;

   assign bif.fifo_slots_free = par_mode ? free_d2 : slots_dir;

   always @(posedge clock) cyc <= cyc + 1;

   // record every strobed word with its cycle; note nonzero data when idle
   always @(negedge clock) begin
      if (bif.blit_valid) begin
         mon_w.push_back({bif.blit_privaledge, bif.blit_command});
         mon_c.push_back(cyc);
      end else if (bif.blit_command != 32'h0 || bif.blit_privaledge != 1'b0) begin
         nz_err <= nz_err + 1;
      end
   end

   // parser FIFO: random drain, one push per strobe, slot count delayed 2 cycles
   always @(posedge clock) begin
      int nxt;
      nxt = occ;
      if (par_mode) begin
         if (nxt > 0 && $urandom_range(1) == 0) nxt = nxt - 1;
         if (bif.blit_valid) nxt = nxt + 1;
         if (nxt > DEPTH) par_ovf <= 1'b1;
      end else begin
         nxt = 0;
      end
      occ     <= nxt;
      free_d1 <= 10'(DEPTH - occ);
      free_d2 <= free_d1;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clock);
      #1;
   endtask

   function automatic req_t rand_req();
      req_t r;
      r.op = 2'($urandom_range(3));       r.priv = 1'($urandom_range(1));
      r.color = 8'($urandom);
      r.x1 = 16'($urandom);  r.y1 = 16'($urandom);  r.x2 = 16'($urandom);  r.y2 = 16'($urandom);
      r.sx = 16'($urandom);  r.sy = 16'($urandom);
      r.dst_stride = 16'($urandom);  r.src_stride = 16'($urandom);
      r.cx1 = 16'($urandom); r.cy1 = 16'($urandom); r.cx2 = 16'($urandom); r.cy2 = 16'($urandom);
      r.ox = 16'($urandom);  r.oy = 16'($urandom);
      r.dst_addr = 26'($urandom); r.src_addr = 26'($urandom); r.font_addr = 26'($urandom);
      r.fw = 8'($urandom);   r.fh = 8'($urandom);
      return r;
   endfunction

   task automatic drive(input req_t r);
      bif.req_op = r.op;            bif.req_priv = r.priv;        bif.req_color = r.color;
      bif.req_x1 = r.x1;            bif.req_y1 = r.y1;            bif.req_x2 = r.x2;
      bif.req_y2 = r.y2;            bif.req_src_x = r.sx;         bif.req_src_y = r.sy;
      bif.req_dest_stride = r.dst_stride;  bif.req_src_stride = r.src_stride;
      bif.req_dest_addr = r.dst_addr;      bif.req_src_addr = r.src_addr;
      bif.req_font_addr = r.font_addr;
      bif.req_clip_x1 = r.cx1;      bif.req_clip_y1 = r.cy1;
      bif.req_clip_x2 = r.cx2;      bif.req_clip_y2 = r.cy2;
      bif.req_offset_x = r.ox;      bif.req_offset_y = r.oy;
      bif.req_font_w = r.fw;        bif.req_font_h = r.fh;
   endtask

   // reference word list, straight from the command format table
   task automatic build_exp(input req_t r);
      exp_q.delete();
      case (r.op)
         2'd0: exp_q.push_back({r.priv, 32'h0});
         2'd1, 2'd2: begin
            exp_q.push_back({r.priv, 8'(r.op), 16'h0, r.color});
            exp_q.push_back({r.priv, r.y1, r.x1});
            exp_q.push_back({r.priv, r.y2, r.x2});
            if (r.op == 2'd2) exp_q.push_back({r.priv, r.sy, r.sx});
         end
         default: begin
            exp_q.push_back({r.priv, 8'hFF, 8'h00, r.dst_stride});
            exp_q.push_back({r.priv, 6'h0, r.dst_addr});
            exp_q.push_back({r.priv, r.cy1, r.cx1});
            exp_q.push_back({r.priv, r.cy2, r.cx2});
            exp_q.push_back({r.priv, r.oy, r.ox});
            exp_q.push_back({r.priv, 6'h0, r.src_addr});
            exp_q.push_back({r.priv, 16'h0, r.src_stride});
            exp_q.push_back({r.priv, 6'h0, r.font_addr});
            exp_q.push_back({r.priv, 16'h0, r.fh, r.fw});
         end
      endcase
   endtask

   // present r at the first ready cycle; acc is the acceptance edge count
   task automatic accept(input req_t r, output int acc);
      acc = -1;
      for (int i = 0; i < 300; i++) begin
         if (bif.req_ready) begin
            drive(r);
            bif.req_valid = 1'b1;
            tick();
            acc = cyc;
            return;
         end
         bif.req_valid = 1'b0;
         tick();
      end
      chk("accept_timeout", {63'd0, bif.req_ready}, 64'd1);
   endtask

   // mode 0: valid low; 1: random junk while busy; 2: leave inputs as they are
   task automatic wait_idle(input int mode, output int rdy);
      rdy = -1;
      if (mode == 0) bif.req_valid = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (bif.req_ready) begin
            if (mode != 2) bif.req_valid = 1'b0;
            rdy = cyc;
            return;
         end
         if (mode == 1) begin
            drive(rand_req());
            bif.req_valid = 1'b1 & 1'($urandom_range(1));
         end
         tick();
      end
      chk("ready_timeout", {63'd0, bif.req_ready}, 64'd1);
   endtask

   task automatic check_burst(input string tag, input req_t r, input int base,
                              input int ref_cyc, input int lat, input int rdy);
      int n;
      int first;
      build_exp(r);
      n = exp_q.size();
      chk({tag, "_len"}, 64'(mon_w.size() - base), 64'(n));
      first = (mon_w.size() > base) ? mon_c[base] : -1000;
      for (int k = 0; k < n; k++) begin
         if (base + k < mon_w.size()) begin
            chk($sformatf("%s_w%0d", tag, k), 64'(mon_w[base + k]), 64'(exp_q[k]));
            if (k > 0) chk($sformatf("%s_gap%0d", tag, k), 64'(mon_c[base + k] - first), 64'(k));
         end
      end
      if (lat >= 0) chk({tag, "_lat"}, 64'(first - ref_cyc), 64'(lat));
      chk({tag, "_ready"}, 64'(rdy - first), 64'(n + 2));
      chk({tag, "_count"}, 64'(cmd_count), 64'(cnt_model));
   endtask

   initial begin
      req_t r, r2;
      int acc, acc2, rdy, rdy2, base, base2, raise;
      drive(rand_req());
      bif.req_valid = 1'b0;
      reset = 1'b1;
      repeat (3) tick();
      chk("rst_ready", {63'd0, bif.req_ready}, 64'd1);
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_valid", {63'd0, bif.blit_valid}, 64'd0);
      chk("rst_cmd", 64'(bif.blit_command), 64'd0);
      chk("rst_priv", {63'd0, bif.blit_privaledge}, 64'd0);
      chk("rst_count", 64'(cmd_count), 64'd0);
      reset = 1'b0;
      tick();

      // DRAW_RECT reference vector
      r = rand_req();
      r.op = 2'd1; r.priv = 1'b0; r.color = 8'h2A;
      r.x1 = 16'd10; r.y1 = 16'd20; r.x2 = 16'd50; r.y2 = 16'd60;
      base = mon_w.size();
      accept(r, acc);
      wait_idle(0, rdy);
      cnt_model++;
      check_burst("draw", r, base, acc, 2, rdy);
      chk("draw_w1_const", 64'(mon_w[base + 1]), 64'h0014000A);

      // SETUP reference vector, privileged; inputs scrambled after capture
      r = rand_req();
      r.op = 2'd3; r.priv = 1'b1; r.dst_stride = 16'd640; r.dst_addr = 26'h100000;
      r.fw = 8'd8; r.fh = 8'd12;
      base = mon_w.size();
      accept(r, acc);
      drive(rand_req());
      wait_idle(0, rdy);
      cnt_model++;
      check_burst("setup", r, base, acc, 2, rdy);
      chk("setup_last_const", 64'(mon_w[base + 8]), {31'd0, 33'h100000C08});

      // SETUP without privilege still emitted unchanged
      r = rand_req();
      r.op = 2'd3; r.priv = 1'b0;
      base = mon_w.size();
      accept(r, acc);
      wait_idle(0, rdy);
      cnt_model++;
      check_burst("setup_np", r, base, acc, 2, rdy);

      // COPY_RECT held off at N+1 free slots, released at N+2
      r = rand_req();
      r.op = 2'd2;
      slots_dir = 10'd5;
      base = mon_w.size();
      accept(r, acc);
      bif.req_valid = 1'b0;
      repeat (8) tick();
      chk("copy_hold_words", 64'(mon_w.size() - base), 64'd0);
      chk("copy_hold_busy", {63'd0, busy}, 64'd1);
      slots_dir = 10'd6;
      raise = cyc;
      wait_idle(0, rdy);
      cnt_model++;
      check_burst("copy", r, base, raise, 2, rdy);
      slots_dir = 10'd1023;

      // back-to-back with req_valid held high; second request waits for SETTLE
      r = rand_req();  r.op = 2'd1;
      r2 = rand_req(); r2.op = 2'd2;
      base = mon_w.size();
      accept(r, acc);
      drive(r2);
      wait_idle(2, rdy);
      tick();
      acc2 = cyc;
      base2 = mon_w.size();
      wait_idle(0, rdy2);
      cnt_model++;
      chk("b2b_accept", 64'(acc2), 64'(rdy + 1));
      chk("b2b_a_len", 64'(base2 - base), 64'd3);
      chk("b2b_idle_ge2", {63'd0, 1'(mon_c[base2] - mon_c[base2 - 1] - 1 >= 2)}, 64'd1);
      cnt_model++;
      check_burst("b2b_b", r2, base2, acc2, 2, rdy2);

      // reset while the 5th SETUP word is on the bus
      r = rand_req();
      r.op = 2'd3;
      base = mon_w.size();
      accept(r, acc);
      bif.req_valid = 1'b0;
      for (int i = 0; i < 50 && mon_w.size() < base + 5; i++) tick();
      reset = 1'b1;
      tick();
      cnt_model = 16'd0;
      chk("mid_rst_valid", {63'd0, bif.blit_valid}, 64'd0);
      chk("mid_rst_cmd", 64'(bif.blit_command), 64'd0);
      chk("mid_rst_count", 64'(cmd_count), 64'd0);
      chk("mid_rst_ready", {63'd0, bif.req_ready}, 64'd1);
      chk("mid_rst_words", 64'(mon_w.size() - base), 64'd5);
      build_exp(r);
      for (int k = 0; k < 5; k++)
         if (base + k < mon_w.size()) chk($sformatf("mid_rst_w%0d", k), 64'(mon_w[base + k]), 64'(exp_q[k]));
      reset = 1'b0;
      tick();
      r = rand_req();
      r.op = 2'd0;
      base = mon_w.size();
      accept(r, acc);
      wait_idle(0, rdy);
      cnt_model++;
      check_burst("nop", r, base, acc, 2, rdy);

      // randomized traffic into the lagging parser FIFO model
      par_mode = 1'b1;
      repeat (3) tick();
      for (int i = 0; i < 1000; i++) begin
         r = rand_req();
         base = mon_w.size();
         accept(r, acc);
         wait_idle(1, rdy);
         cnt_model++;
         check_burst($sformatf("rnd%0d", i), r, base, acc, -1, rdy);
         repeat ($urandom_range(0, 2)) tick();
      end
      chk("parser_overflow", {63'd0, par_ovf}, 64'd0);
      chk("idle_outputs_zero", 64'(nz_err), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
